// File: rtl/midi_rx_if.sv
// Signal bundle between the MIDI receiver and its consumer (game_logic).
// Strobes carry no back-pressure: midi_ready/note_off/frame_err are single-cycle
// pulses; midi_index/velocity are valid from their pulse until the next accepted event.
interface midi_rx_if;
    logic       midi_in;
    logic [6:0] midi_index;
    logic [6:0] velocity;
    logic       midi_ready;
    logic       note_off;
    logic       frame_err;
    logic [1:0] rx_state;

    modport master (
        input  midi_in,
        output midi_index, velocity, midi_ready, note_off, frame_err, rx_state
    );

    modport slave (
        output midi_in,
        input  midi_index, velocity, midi_ready, note_off, frame_err, rx_state
    );
endinterface

// File: rtl/midi_rx.sv
// 8N1 MIDI receiver with running-status note parser; emits note-on/off strobes.
// Optional channel filter: define MIDI_RX_CHANNEL_FILTER_EN to accept only CHANNEL.
module midi_rx #(
    parameter int CLK_FREQ  = 65000000,
    parameter int BAUD      = 31250,
    parameter int NOTE_LOW  = 48,
    parameter int NOTE_HIGH = 79,
    parameter int CHANNEL   = 0
) (
    input  logic      clock,
    input  logic      reset_n,
    midi_rx_if.master bus
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [6:0]    LO      = 7'(NOTE_LOW);
    localparam logic [6:0]    HI      = 7'(NOTE_HIGH);
    localparam logic [3:0]    CHAN    = 4'(CHANNEL);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_e;

    rx_state_e     state_q;
    logic          sync1_q, sync2_q, prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          byte_valid_q, frame_err_q;

    logic [7:0] status_q;
    logic       dcnt_q;
    logic [6:0] note_q;
    logic       evt_on_q, evt_off_q;
    logic [6:0] evt_note_q, evt_vel_q;
    logic [6:0] midi_index_q, velocity_q;
    logic       midi_ready_q, note_off_q;

    // Two flops for metastability, a third only to detect the falling edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= bus.midi_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= S_START;
                        cnt_q   <= HALF_M1;
                    end
                end
                S_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (sync2_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_DATA;
                        cnt_q   <= FULL_M1;
                        bit_q   <= '0;
                    end
                end
                S_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shift_q <= {sync2_q, shift_q[7:1]};
                        cnt_q   <= FULL_M1;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= S_STOP;
                    end
                end
                default: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        byte_valid_q <= sync2_q;
                        frame_err_q  <= !sync2_q;
                        state_q      <= S_IDLE;
                    end
                end
            endcase
        end
    end

    logic       is_rt, is_sys, is_note_msg, is_two_byte, in_range, chan_ok;
    logic [6:0] vel;

    assign vel         = shift_q[6:0];
    assign is_rt       = (shift_q[7:3] == 5'b11111);
    assign is_sys      = (shift_q[7:4] == 4'hF);
    assign is_note_msg = (status_q[7:5] == 3'b100);
    assign is_two_byte = status_q[7] && (status_q[6:4] != 3'b100) && (status_q[6:4] != 3'b101);
    assign in_range    = (note_q >= LO) && (note_q <= HI);
`ifdef MIDI_RX_CHANNEL_FILTER_EN
    assign chan_ok = (status_q[3:0] == CHAN);
`else
    // Channel bits only matter in the filtered build; every channel passes here.
    assign chan_ok = 1'b1 || (status_q[3:0] == CHAN);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            status_q     <= '0;
            dcnt_q       <= 1'b0;
            note_q       <= '0;
            evt_on_q     <= 1'b0;
            evt_off_q    <= 1'b0;
            evt_note_q   <= '0;
            evt_vel_q    <= '0;
            midi_index_q <= '0;
            velocity_q   <= '0;
            midi_ready_q <= 1'b0;
            note_off_q   <= 1'b0;
        end else begin
            evt_on_q  <= 1'b0;
            evt_off_q <= 1'b0;
            if (frame_err_q) begin
                dcnt_q <= 1'b0;
            end else if (byte_valid_q && !is_rt) begin
                if (is_sys) begin
                    status_q <= '0;
                    dcnt_q   <= 1'b0;
                end else if (shift_q[7]) begin
                    status_q <= shift_q;
                    dcnt_q   <= 1'b0;
                end else if (is_note_msg) begin
                    if (!dcnt_q) begin
                        note_q <= shift_q[6:0];
                        dcnt_q <= 1'b1;
                    end else begin
                        dcnt_q <= 1'b0;
                        if (in_range && chan_ok) begin
                            evt_note_q <= note_q;
                            evt_vel_q  <= vel;
                            evt_on_q   <= status_q[4] && (vel != 7'd0);
                            evt_off_q  <= !(status_q[4] && (vel != 7'd0));
                        end
                    end
                end else if (is_two_byte) begin
                    dcnt_q <= !dcnt_q;
                end
            end

            // Second stage: the resolved event becomes visible one clock later.
            midi_ready_q <= evt_on_q;
            note_off_q   <= evt_off_q;
            if (evt_on_q || evt_off_q) midi_index_q <= evt_note_q;
            if (evt_on_q) velocity_q <= evt_vel_q;
        end
    end

    assign bus.midi_index = midi_index_q;
    assign bus.velocity   = velocity_q;
    assign bus.midi_ready = midi_ready_q;
    assign bus.note_off   = note_off_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.rx_state   = state_q;
endmodule

// File: doc/midi_rx.md
Name: midi_rx

Overview:
- Serial MIDI receiver and note parser. Drives midi_index/midi_ready into game_logic (game_logic derives freq_id = midi_index - 48).
- Decodes the 31250-baud 8N1 MIDI stream from the DIN opto-isolator pin and tracks running status.
- Emits one-cycle pulses for accepted note-on and note-off events on the system clock domain.

Parameters:
- CLK_FREQ, 65000000, system clock frequency in Hz (1024x768 pixel clock)
- BAUD, 31250, MIDI bit rate
- NOTE_LOW, 48, lowest accepted note number
- NOTE_HIGH, 79, highest accepted note number (32 notes, matching 5-bit freq_id)
- CHANNEL, 0, MIDI channel accepted when the channel filter is compiled in

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- midi_in  input  1  raw serial line, idle high, asynchronous to clock
- midi_index  output  7  note number of last accepted note event
- velocity  output  7  velocity of last accepted note-on
- midi_ready  output  1  one-cycle pulse per accepted note-on
- note_off  output  1  one-cycle pulse per accepted note-off
- frame_err  output  1  one-cycle pulse on bad stop bit

Behaviour:
- Interface: one clock, clock. reset_n is asynchronous, active-low.
- Reset state: all outputs 0, running status cleared, bit FSM in IDLE, synchroniser flops set to 1.
- Input sync: midi_in passes through 2 flops before any use.
- Bit timing:
  - DIV = CLK_FREQ/BAUD, integer division (2080 at defaults). Counter width $clog2(DIV).
- Bit FSM:
  - IDLE: on synced falling edge, go to START and load the counter with DIV/2.
  - START: at counter expiry, resample. If 1 (glitch), return to IDLE with no error. If 0, go to DATA and reload DIV.
  - DATA: sample 8 bits LSB first, one every DIV cycles, then go to STOP.
  - STOP: sample. If 1, byte_valid pulses for one cycle. If 0, frame_err pulses and the byte is discarded. Either way, go to IDLE. A new start edge is accepted from the cycle after STOP.
- Parser, driven by byte_valid:
  - 0xF8-0xFF (real-time): ignored. Running status and data count unchanged.
  - 0xF0-0xF7: clear running status. Following data bytes are ignored until the next channel status.
  - 0x80-0xEF: latch as running status, data count = 0.
  - Data byte (bit7=0) with running status 0x8n/0x9n: first byte latched as note, second as vel, then data count returns to 0 (running status kept).
  - Data byte with any other running status: consumed and discarded. 2-byte messages are A0-E0 except C0/D0; 1-byte messages are C0/D0.
- Event resolution, on the cycle the second data byte is decoded:
  - Event accepted only if NOTE_LOW <= note <= NOTE_HIGH (inclusive). Otherwise dropped silently.
  - 0x9n with vel != 0: midi_index <= note, velocity <= vel, midi_ready = 1 on the next clock edge.
  - 0x8n, or 0x9n with vel == 0: midi_index <= note, note_off = 1. velocity unchanged.
- Latency: midi_ready/note_off rise exactly 2 clocks after the STOP-bit sample of the final byte.
  - Pulses are exactly 1 cycle wide.
  - midi_index/velocity hold until the next accepted event.
- Frame error: discard the byte, reset data count to 0, keep running status.
- Reset mid-byte or mid-message: everything returns to reset state immediately. The line is re-acquired on the next falling edge.
- midi_ready and note_off are never asserted in the same cycle.

Optional Feature:
- MIDI_RX_CHANNEL_FILTER_EN
  - Defined: note events are accepted only when status[3:0] == CHANNEL. Other channels are parsed, updating running status and data count, but produce no pulse.
  - Undefined: all 16 channels are accepted and CHANNEL is unused.

Test Plan:
- Serial bytes 0x90,0x3C,0x64 at DIV=2080 -> midi_ready one-cycle pulse 2 clocks after last STOP sample; midi_index=60, velocity=100, note_off=0.
- 0x90,0x30,0x40 then running-status 0x34,0x40 then 0x34,0x00 -> two midi_ready pulses (indices 48, 52), then note_off with midi_index=52, velocity still 64.
- 0x90,0x2F,0x7F and 0x90,0x50,0x7F -> no pulses (47 < NOTE_LOW, 80 > NOTE_HIGH); 0x90,0x4F,0x7F -> midi_ready, index 79.
- 0x90,0x3C, then 0xF8, then 0x64 -> midi_ready index 60; a 0xF0 before 0x64 instead -> no pulse.
- Stop bit held 0 on 0x3C, then 0x3C,0x64 -> frame_err pulse; next pair yields midi_ready index 60. A 400-cycle low glitch on idle line -> no byte, no error.
- reset_n low for 1 cycle mid-DATA of 0x64 -> all outputs 0, no pulse. With MIDI_RX_CHANNEL_FILTER_EN and CHANNEL=0: 0x91,0x3C,0x64 -> no pulse; 0x90,0x3C,0x64 -> pulse.
